// File: rtl/fp16_dot_acc.sv
// Accumulates a stream of fp16 products into an fp16 dot product, one term per 4 cycles.
// Latency: accept->acc update 3 edges; p_ready low while a term is in flight or a result waits.
module fp16_dot_acc #(
    parameter int MAX_TERMS = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk_50,
    input  logic             reset_50,
    input  logic             p_valid,
    input  logic [15:0]      p_data,
    input  logic             p_last,
    output logic             p_ready,
    output logic             sum_valid,
    output logic [15:0]      sum_data,
    output logic [CNT_W-1:0] sum_terms,
    input  logic             sum_ready
);

    typedef enum logic [2:0] {WAIT, ALIGN, ADD, NORM, OUT} state_t;
    state_t state, state_nx;

    logic [15:0]      acc, term;
    logic [CNT_W-1:0] cnt;
    logic             last_q;

    // align-stage registers
    logic        a_sign, sub_q, byp_q;
    logic [4:0]  a_exp;
    logic [10:0] a_man, b_man;
    logic [15:0] byp_val;
    // add-stage register
    logic [11:0] sum_q;

    // align combinational
    logic        x_big;
    logic [4:0]  diff;
    logic [10:0] big_man, sml_man;
    logic        big_sign;
    logic [4:0]  big_exp;

    always_comb begin
        x_big    = (acc[14:0] >= term[14:0]);
        big_sign = x_big ? acc[15] : term[15];
        big_exp  = x_big ? acc[14:10] : term[14:10];
        big_man  = x_big ? {1'b1, acc[9:0]} : {1'b1, term[9:0]};
        diff     = x_big ? (acc[14:10] - term[14:10]) : (term[14:10] - acc[14:10]);
        // an 11-bit mantissa shifted by 11 or more naturally becomes zero
        sml_man  = (x_big ? {1'b1, term[9:0]} : {1'b1, acc[9:0]}) >> diff;
    end

    // normalize combinational
    logic [3:0]         lz;
    logic signed [6:0]  n_exp;
    logic [9:0]         n_man;
    logic [15:0]        n_res;

    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (sum_q[i]) lz = 4'(10 - i);
        end
        if (sum_q[11]) begin
            n_man = sum_q[10:1];
            n_exp = signed'({2'b00, a_exp}) + 7'sd1;
        end else begin
            n_man = 10'(sum_q[10:0] << lz);
            n_exp = signed'({2'b00, a_exp}) - signed'({3'b000, lz});
        end
        if (byp_q)             n_res = byp_val;
        else if (sum_q == '0)  n_res = 16'h0000;
        else if (n_exp > 7'sd30) n_res = {a_sign, 15'h7BFF};
        else if (n_exp < 7'sd1)  n_res = 16'h0000;
        else                   n_res = {a_sign, n_exp[4:0], n_man};
    end

    always_ff @(posedge clk_50) begin
        if (reset_50) state <= WAIT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT:    if (p_valid) state_nx = ALIGN;
            ALIGN:   state_nx = ADD;
            ADD:     state_nx = NORM;
            NORM:    state_nx = last_q ? OUT : WAIT;
            OUT:     if (sum_ready) state_nx = WAIT;
            default: state_nx = WAIT;
        endcase
    end

    always_comb begin
        p_ready   = (state == WAIT);
        sum_valid = (state == OUT);
    end

    always_ff @(posedge clk_50) begin
        if (reset_50) begin
            acc       <= '0;
            cnt       <= '0;
            term      <= '0;
            last_q    <= 1'b0;
            sum_data  <= '0;
            sum_terms <= '0;
            a_sign    <= 1'b0;
            sub_q     <= 1'b0;
            byp_q     <= 1'b0;
            a_exp     <= '0;
            a_man     <= '0;
            b_man     <= '0;
            byp_val   <= '0;
            sum_q     <= '0;
        end else begin
            case (state)
                WAIT: if (p_valid) begin
                    term   <= p_data;
                    last_q <= p_last | ((cnt + 1'b1) == CNT_W'(MAX_TERMS));
                    cnt    <= cnt + 1'b1;
                end
                ALIGN: begin
                    a_sign  <= big_sign;
                    a_exp   <= big_exp;
                    a_man   <= big_man;
                    b_man   <= sml_man;
                    sub_q   <= acc[15] ^ term[15];
                    byp_q   <= (acc[14:10] == 5'd0) || (term[14:10] == 5'd0);
                    byp_val <= (acc[14:10] == 5'd0) ? term : acc;
                end
                ADD: sum_q <= sub_q ? ({1'b0, a_man} - {1'b0, b_man})
                                    : ({1'b0, a_man} + {1'b0, b_man});
                NORM: begin
                    acc <= n_res;
                    if (last_q) begin
                        sum_data  <= n_res;
                        sum_terms <= cnt;
                    end
                end
                OUT: if (sum_ready) begin
                    acc <= '0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_dot_acc.sv
// Self-checking bench for fp16_dot_acc: directed cases plus random streams vs an arithmetic model.
module tb_fp16_dot_acc;

    logic        clk_50 = 1'b0;
    logic        reset_50 = 1'b1;
    logic        p_valid = 1'b0;
    logic [15:0] p_data = '0;
    logic        p_last = 1'b0;
    logic        p_ready;
    logic        sum_valid;
    logic [15:0] sum_data;
    logic [4:0]  sum_terms;
    logic        sum_ready = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_50 = ~clk_50;

    fp16_dot_acc #(.MAX_TERMS(16), .CNT_W(5)) dut (
        .clk_50(clk_50), .reset_50(reset_50),
        .p_valid(p_valid), .p_data(p_data), .p_last(p_last), .p_ready(p_ready),
        .sum_valid(sum_valid), .sum_data(sum_data), .sum_terms(sum_terms),
        .sum_ready(sum_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference: fp16 add with truncation, flush-to-zero, saturation, no inf/NaN.
    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, s, e, sh;
        logic sg;
        logic [15:0] r;
        if (a[14:10] == 0) return b;
        if (b[14:10] == 0) return a;
        ea = a[14:10]; eb = b[14:10];
        ma = 1024 + a[9:0]; mb = 1024 + b[9:0];
        if (!(ea > eb || (ea == eb && ma >= mb))) begin
            r = a; a = b; b = r;
            ea = a[14:10]; eb = b[14:10];
            ma = 1024 + a[9:0]; mb = 1024 + b[9:0];
        end
        sh = ea - eb;
        mb = (sh >= 11) ? 0 : mb / (1 << sh);
        sg = a[15];
        s  = (a[15] == b[15]) ? ma + mb : ma - mb;
        if (s == 0) return 16'h0000;
        e = ea;
        while (s >= 2048) begin s = s / 2; e++; end
        while (s < 1024)  begin s = s * 2; e--; end
        if (e > 30) return {sg, 15'h7BFF};
        if (e < 1)  return 16'h0000;
        r = {sg, 5'(e), 10'(s - 1024)};
        return r;
    endfunction

    task automatic push(input logic [15:0] d, input logic l);
        int t;
        t = 0;
        @(negedge clk_50);
        while (!p_ready && t < 100) begin @(negedge clk_50); t++; end
        if (!p_ready) begin chk("push_timeout", 32'd0, 32'd1); return; end
        p_valid = 1'b1; p_data = d; p_last = l;
        @(posedge clk_50); #1;
        p_valid = 1'b0; p_data = 16'($urandom); p_last = 1'($urandom);
    endtask

    task automatic wait_sum(output bit ok);
        int t;
        t = 0;
        @(negedge clk_50);
        while (!sum_valid && t < 100) begin @(negedge clk_50); t++; end
        ok = sum_valid;
        if (!ok) chk("sum_timeout", 32'd0, 32'd1);
    endtask

    task automatic pull(input string tag, input logic [15:0] ed, input logic [4:0] et, input int hold);
        bit ok;
        wait_sum(ok);
        if (!ok) return;
        chk({tag, "_data"}, 32'(sum_data), 32'(ed));
        chk({tag, "_terms"}, 32'(sum_terms), 32'(et));
        repeat (hold) @(negedge clk_50);
        sum_ready = 1'b1;
        @(posedge clk_50); #1;
        sum_ready = 1'b0;
        @(negedge clk_50);
        chk({tag, "_handoff_vld"}, 32'(sum_valid), 32'd0);
        chk({tag, "_handoff_rdy"}, 32'(p_ready), 32'd1);
    endtask

    function automatic logic [15:0] rnd_term();
        logic [15:0] v;
        if ($urandom_range(0, 7) == 0) return 16'h0000;
        v[15]    = 1'($urandom);
        v[14:10] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'($urandom_range(12, 20));
        v[9:0]   = 10'($urandom);
        return v;
    endfunction

    initial begin
        logic [15:0] macc, tv;
        int mcnt, n;
        bit ok;

        repeat (3) @(posedge clk_50);
        #1 reset_50 = 1'b0;
        @(negedge clk_50);
        chk("rst_p_ready", 32'(p_ready), 32'd1);
        chk("rst_sum_valid", 32'(sum_valid), 32'd0);
        chk("rst_sum_data", 32'(sum_data), 32'd0);
        chk("rst_sum_terms", 32'(sum_terms), 32'd0);

        // latency and p_ready profile
        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b1);
        @(negedge clk_50); chk("lat_align_rdy", 32'(p_ready), 32'd0); chk("lat_align_vld", 32'(sum_valid), 32'd0);
        @(negedge clk_50); chk("lat_add_rdy", 32'(p_ready), 32'd0); chk("lat_add_vld", 32'(sum_valid), 32'd0);
        @(negedge clk_50); chk("lat_norm_rdy", 32'(p_ready), 32'd0); chk("lat_norm_vld", 32'(sum_valid), 32'd0);
        @(negedge clk_50); chk("lat_e3_vld", 32'(sum_valid), 32'd1);
        pull("one_plus_one", 16'h4000, 5'd2, 0);

        push(16'h3C00, 1'b0); push(16'hBC00, 1'b1);
        pull("cancel", 16'h0000, 5'd2, 0);
        push(16'h3C00, 1'b0); push(16'h3C00, 1'b0); push(16'h4000, 1'b1);
        pull("three", 16'h4400, 5'd3, 1);
        push(16'h7BFF, 1'b0); push(16'h7BFF, 1'b1);
        pull("saturate", 16'h7BFF, 5'd2, 0);
        push(16'h6400, 1'b0); push(16'h3C00, 1'b1);
        pull("diff10", 16'h6401, 5'd2, 0);
        push(16'h6800, 1'b0); push(16'h3C00, 1'b1);
        pull("diff11", 16'h6800, 5'd2, 0);
        push(16'h0000, 1'b1);
        pull("zero", 16'h0000, 5'd1, 0);

        // forced flush at MAX_TERMS, then fresh restart
        for (int i = 0; i < 16; i++) push(16'h3C00, 1'b0);
        pull("flush16", 16'h4C00, 5'd16, 0);
        push(16'h4000, 1'b1);
        pull("restart", 16'h4000, 5'd1, 0);

        // result held under backpressure while p_valid is asserted
        push(16'h3C00, 1'b0); push(16'h4000, 1'b1);
        wait_sum(ok);
        p_valid = 1'b1; p_data = 16'h5555; p_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_50);
            chk("hold_vld", 32'(sum_valid), 32'd1);
            chk("hold_data", 32'(sum_data), 32'h4200);
            chk("hold_terms", 32'(sum_terms), 32'd2);
            chk("hold_rdy", 32'(p_ready), 32'd0);
        end
        p_valid = 1'b0; sum_ready = 1'b1;
        @(posedge clk_50); #1 sum_ready = 1'b0;
        @(negedge clk_50);
        chk("hold_after_vld", 32'(sum_valid), 32'd0);
        chk("hold_after_rdy", 32'(p_ready), 32'd1);
        push(16'h3C00, 1'b1);
        pull("after_hold", 16'h3C00, 5'd1, 0);

        // reset during ADD of a last term
        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b1);
        @(posedge clk_50); #1 reset_50 = 1'b1;
        @(posedge clk_50); #1 reset_50 = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            repeat (10) begin @(negedge clk_50); if (sum_valid) seen = 1'b1; end
            chk("rst_mid_no_vld", 32'(seen), 32'd0);
            chk("rst_mid_rdy", 32'(p_ready), 32'd1);
        end
        push(16'h4000, 1'b1);
        pull("post_rst", 16'h4000, 5'd1, 0);

        // random streams against the model
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(1, 20);
            macc = 16'h0000; mcnt = 0;
            for (int i = 0; i < n; i++) begin
                tv = rnd_term();
                repeat ($urandom_range(0, 2)) @(negedge clk_50);
                push(tv, 1'(i == n - 1));
                macc = fp_add(macc, tv);
                mcnt++;
                if (i == n - 1 || mcnt == 16) begin
                    pull("rand", macc, 5'(mcnt), $urandom_range(0, 3));
                    macc = 16'h0000; mcnt = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
